// File: rtl/inst_encode_loader.sv
// Packs field-level RV32I instruction requests into 32-bit words and writes them
// sequentially into instruction memory. Optional immediate range checking: ENC_RANGE_CHECK_EN.
`ifndef _INST_WIDTH_
`define _INST_WIDTH_ 32
`endif

module inst_encode_loader #(
    parameter int unsigned INST_WIDTH = `_INST_WIDTH_,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_Clear,
    input  logic                  i_Valid,
    output logic                  o_Ready,
    input  logic [2:0]            i_Fmt,
    input  logic [6:0]            i_Opcode,
    input  logic [4:0]            i_Rd,
    input  logic [4:0]            i_Rs1,
    input  logic [4:0]            i_Rs2,
    input  logic [2:0]            i_Func3,
    input  logic [6:0]            i_Func7,
    input  logic [31:0]           i_Imm,
    output logic                  o_MemWrEn,
    output logic [ADDR_WIDTH-1:0] o_MemAddr,
    output logic [INST_WIDTH-1:0] o_MemWrData,
    input  logic                  i_MemWrReady,
    output logic [ADDR_WIDTH:0]   o_Count,
    output logic                  o_Full,
    output logic                  o_Err
);

    localparam int unsigned CW  = ADDR_WIDTH + 1;
    localparam int unsigned CAP = 1 << ADDR_WIDTH;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_ready;
    logic                  r_wren;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [INST_WIDTH-1:0] r_data;
    logic [CW-1:0]         r_count;
    logic                  r_full;
    logic                  r_err;

    logic                  w_ready_nxt;
    logic                  w_wren_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [INST_WIDTH-1:0] w_data_nxt;
    logic [CW-1:0]         w_count_nxt;
    logic                  w_full_nxt;
    logic                  w_err_nxt;

    logic                  w_accept;
    logic                  w_legal;
    logic [31:0]           w_enc;
    logic [CW-1:0]         w_count_inc;

    assign w_accept    = i_Valid & r_ready;
    assign w_count_inc = r_count + CW'(1);

    // Field packing for each instruction format
    always_comb begin
        w_enc = 32'h0;
        case (i_Fmt)
            FMT_R: w_enc = {i_Func7, i_Rs2, i_Rs1, i_Func3, i_Rd, i_Opcode};
            FMT_I: w_enc = {i_Imm[11:0], i_Rs1, i_Func3, i_Rd, i_Opcode};
            FMT_S: w_enc = {i_Imm[11:5], i_Rs2, i_Rs1, i_Func3, i_Imm[4:0], i_Opcode};
            FMT_B: w_enc = {i_Imm[12], i_Imm[10:5], i_Rs2, i_Rs1, i_Func3,
                            i_Imm[4:1], i_Imm[11], i_Opcode};
            FMT_U: w_enc = {i_Imm[31:12], i_Rd, i_Opcode};
            FMT_J: w_enc = {i_Imm[20], i_Imm[10:1], i_Imm[11], i_Imm[19:12], i_Rd, i_Opcode};
            default: w_enc = 32'h0;
        endcase
    end

    // Request legality: format code, branch/jump alignment, optional immediate range
    always_comb begin
        w_legal = 1'b1;
        if (i_Fmt > FMT_J) begin
            w_legal = 1'b0;
        end
        if ((i_Fmt == FMT_B || i_Fmt == FMT_J) && i_Imm[0]) begin
            w_legal = 1'b0;
        end
`ifdef ENC_RANGE_CHECK_EN
        case (i_Fmt)
            FMT_I, FMT_S: if (!((&i_Imm[31:11]) || !(|i_Imm[31:11]))) w_legal = 1'b0;
            FMT_B:        if (!((&i_Imm[31:12]) || !(|i_Imm[31:12]))) w_legal = 1'b0;
            FMT_J:        if (!((&i_Imm[31:20]) || !(|i_Imm[31:20]))) w_legal = 1'b0;
            FMT_U:        if (|i_Imm[11:0]) w_legal = 1'b0;
            default:      ;
        endcase
`endif
    end

    // State register plus registered outputs
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_wren  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= w_ready_nxt;
            r_wren  <= w_wren_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_count <= w_count_nxt;
            r_full  <= w_full_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state logic; clear overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        if (i_Clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_legal) begin
                        w_state_nxt = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (i_MemWrReady) begin
                        w_state_nxt = (w_count_inc == CW'(CAP)) ? S_FULL : S_IDLE;
                    end
                end
                S_FULL:  w_state_nxt = S_FULL;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output next-values; handshake flags follow the upcoming state
    always_comb begin
        w_ready_nxt = (w_state_nxt == S_IDLE);
        w_wren_nxt  = (w_state_nxt == S_WRITE);
        w_full_nxt  = (w_state_nxt == S_FULL);
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_count_nxt = r_count;
        w_err_nxt   = 1'b0;
        if (i_Clear) begin
            w_addr_nxt  = '0;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            w_data_nxt = INST_WIDTH'(w_enc);
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (i_MemWrReady) begin
                        w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
                        w_count_nxt = w_count_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_Ready     = r_ready;
    assign o_MemWrEn   = r_wren;
    assign o_MemAddr   = r_addr;
    assign o_MemWrData = r_data;
    assign o_Count     = r_count;
    assign o_Full      = r_full;
    assign o_Err       = r_err;

endmodule

// File: tb/tb_inst_encode_loader.sv
// Directed testbench for inst_encode_loader, built with a 4-word memory to reach the full condition.
module tb_inst_encode_loader;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        valid;
    logic        ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        wren;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        wrready;
    logic [2:0]  count;
    logic        full;
    logic        err;

    int errors = 0;
    int checks = 0;

    inst_encode_loader #(.INST_WIDTH(32), .ADDR_WIDTH(2)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Clear(clear), .i_Valid(valid), .o_Ready(ready),
        .i_Fmt(fmt), .i_Opcode(opcode), .i_Rd(rd), .i_Rs1(rs1), .i_Rs2(rs2),
        .i_Func3(f3), .i_Func7(f7), .i_Imm(imm), .o_MemWrEn(wren), .o_MemAddr(addr),
        .o_MemWrData(wdata), .i_MemWrReady(wrready), .o_Count(count), .o_Full(full), .o_Err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Presents one request at a negedge; returns at the negedge after the accepting posedge
    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] fn3,
                         input logic [6:0] fn7, input logic [31:0] im);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; f3 = fn3; f7 = fn7; imm = im;
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", ready); end
        checks++; if (wren !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b expected 0", wren); end
        checks++; if ({addr, wdata, count, full, err} !== 39'h0) begin errors++;
            $display("FAIL rst_outputs: got addr=%h data=%h count=%0d full=%b err=%b expected all 0", addr, wdata, count, full, err); end
        rst_n = 1'b1;
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready_idle: got %b expected 1", ready); end
    endtask

    task automatic test_r_type();
        drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0);
        checks++; if (wren !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL r_handshake: got wren=%b ready=%b expected 1/0", wren, ready); end
        checks++; if (wdata !== 32'h002081B3 || addr !== 2'd0) begin errors++; $display("FAIL r_word: got %h@%0d expected 002081b3@0", wdata, addr); end
        tick();
        checks++; if (wren !== 1'b0 || ready !== 1'b1 || count !== 3'd1 || addr !== 2'd1) begin errors++;
            $display("FAIL r_done: got wren=%b ready=%b count=%0d addr=%0d expected 0/1/1/1", wren, ready, count, addr); end
    endtask

    task automatic test_i_s();
        do_clear();
        checks++; if (count !== 3'd0 || addr !== 2'd0) begin errors++; $display("FAIL clr_count: got count=%0d addr=%0d expected 0/0", count, addr); end
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5);
        checks++; if (wdata !== 32'h00500093 || addr !== 2'd0 || ready !== 1'b0) begin errors++;
            $display("FAIL i_word: got %h@%0d ready=%b expected 00500093@0 ready=0", wdata, addr, ready); end
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL i_ready: got %b expected 1", ready); end
        drive(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8);
        checks++; if (wdata !== 32'h0020A423 || addr !== 2'd1 || ready !== 1'b0) begin errors++;
            $display("FAIL s_word: got %h@%0d ready=%b expected 0020a423@1 ready=0", wdata, addr, ready); end
        tick();
        checks++; if (count !== 3'd2 || ready !== 1'b1) begin errors++; $display("FAIL s_count: got count=%0d ready=%b expected 2/1", count, ready); end
    endtask

    task automatic test_b_j_u();
        do_clear();
        drive(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC);
        checks++; if (wdata !== 32'hFE208EE3) begin errors++; $display("FAIL b_word: got %h expected fe208ee3", wdata); end
        tick();
        drive(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048);
        checks++; if (wdata !== 32'h001000EF || addr !== 2'd1) begin errors++; $display("FAIL j_word: got %h@%0d expected 001000ef@1", wdata, addr); end
        tick();
        drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000);
        checks++; if (wdata !== 32'h123452B7 || addr !== 2'd2) begin errors++; $display("FAIL u_word: got %h@%0d expected 123452b7@2", wdata, addr); end
        tick();
        checks++; if (count !== 3'd3 || full !== 1'b0) begin errors++; $display("FAIL bju_count: got count=%0d full=%b expected 3/0", count, full); end
    endtask

    task automatic test_backpressure();
        do_clear();
        wrready = 1'b0;
        drive(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF);
        for (int i = 0; i < 4; i++) begin
            checks++; if (wren !== 1'b1 || ready !== 1'b0 || wdata !== 32'hFFF18113 || addr !== 2'd0 || count !== 3'd0) begin errors++;
                $display("FAIL bp_hold%0d: got wren=%b ready=%b data=%h addr=%0d count=%0d expected 1/0/fff18113/0/0", i, wren, ready, wdata, addr, count); end
            if (i == 3) wrready = 1'b1;
            tick();
        end
        checks++; if (wren !== 1'b0 || count !== 3'd1 || ready !== 1'b1) begin errors++;
            $display("FAIL bp_done: got wren=%b count=%0d ready=%b expected 0/1/1", wren, count, ready); end
    endtask

    task automatic test_errors();
        do_clear();
        drive(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0);
        checks++; if (err !== 1'b1 || wren !== 1'b0 || ready !== 1'b1) begin errors++;
            $display("FAIL fmt7_err: got err=%b wren=%b ready=%b expected 1/0/1", err, wren, ready); end
        tick();
        checks++; if (err !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL err_pulse: got err=%b count=%0d expected 0/0", err, count); end
        drive(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3);
        checks++; if (err !== 1'b1 || wren !== 1'b0) begin errors++; $display("FAIL b_odd_err: got err=%b wren=%b expected 1/0", err, wren); end
        tick();
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096);
`ifdef ENC_RANGE_CHECK_EN
        checks++; if (err !== 1'b1 || wren !== 1'b0) begin errors++; $display("FAIL i_range_err: got err=%b wren=%b expected 1/0", err, wren); end
        tick();
`else
        checks++; if (err !== 1'b0 || wren !== 1'b1 || wdata !== 32'h00000093) begin errors++;
            $display("FAIL i_trunc: got err=%b wren=%b data=%h expected 0/1/00000093", err, wren, wdata); end
        tick();
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL i_trunc_count: got %0d expected 1", count); end
`endif
    endtask

    task automatic test_fill();
        do_clear();
        for (int k = 0; k < 4; k++) begin
            drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, k);
            checks++; if (addr !== 2'(k) || wren !== 1'b1) begin errors++; $display("FAIL fill_addr%0d: got addr=%0d wren=%b expected %0d/1", k, addr, wren, k); end
            tick();
        end
        checks++; if (full !== 1'b1 || ready !== 1'b0 || count !== 3'd4 || addr !== 2'd0) begin errors++;
            $display("FAIL fill_full: got full=%b ready=%b count=%0d addr=%0d expected 1/0/4/0", full, ready, count, addr); end
        drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0);
        checks++; if (wren !== 1'b0 || count !== 3'd4 || full !== 1'b1) begin errors++;
            $display("FAIL full_ignore: got wren=%b count=%0d full=%b expected 0/4/1", wren, count, full); end
        do_clear();
        checks++; if (count !== 3'd0 || full !== 1'b0 || ready !== 1'b1) begin errors++;
            $display("FAIL full_clear: got count=%0d full=%b ready=%b expected 0/0/1", count, full, ready); end
        drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0);
        checks++; if (addr !== 2'd0 || wren !== 1'b1) begin errors++; $display("FAIL clear_addr: got addr=%0d wren=%b expected 0/1", addr, wren); end
        tick();
    endtask

    task automatic test_clear_mid_write();
        do_clear();
        wrready = 1'b0;
        drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (wren !== 1'b0 || count !== 3'd0 || ready !== 1'b1) begin errors++;
            $display("FAIL clr_mid_write: got wren=%b count=%0d ready=%b expected 0/0/1", wren, count, ready); end
        wrready = 1'b1;
    endtask

    task automatic test_async_reset();
        wrready = 1'b0;
        drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000);
        checks++; if (wren !== 1'b1) begin errors++; $display("FAIL arst_pre: got wren=%b expected 1", wren); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (wren !== 1'b0 || ready !== 1'b0 || wdata !== 32'h0 || count !== 3'd0) begin errors++;
            $display("FAIL arst_mid_write: got wren=%b ready=%b data=%h count=%0d expected 0/0/0/0", wren, ready, wdata, count); end
        tick();
        rst_n = 1'b1;
        wrready = 1'b1;
        tick();
        checks++; if (ready !== 1'b1 || wren !== 1'b0) begin errors++; $display("FAIL arst_recover: got ready=%b wren=%b expected 1/0", ready, wren); end
    endtask

    initial begin
        rst_n = 1'b1; clear = 1'b0; valid = 1'b0; wrready = 1'b1;
        fmt = 3'd0; opcode = 7'h0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; f3 = 3'd0; f7 = 7'h0; imm = 32'h0;
        #1 rst_n = 1'b0;
        test_reset();
        test_r_type();
        test_i_s();
        test_b_j_u();
        test_backpressure();
        test_errors();
        test_fill();
        test_clear_mid_write();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
